// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// router_pkg : shared types and constants for the 1x3 packet router
// Rev 1.0
// ============================================================================
package router_pkg;

    localparam int DATA_W          = 8;
    localparam int FIFO_DEPTH      = 16;
    localparam int SOFT_RST_CYCLES = 30;
    localparam int c_NUM_PORTS     = 3;

    localparam logic [1:0] c_ADDR_PORT0 = 2'd0;
    localparam logic [1:0] c_ADDR_PORT1 = 2'd1;
    localparam logic [1:0] c_ADDR_PORT2 = 2'd2;
    localparam logic [1:0] c_ADDR_NONE  = 2'd3;

    typedef enum logic [1:0] {
        DECODE       = 2'd0,
        LOAD_DATA    = 2'd1,
        CHECK_PARITY = 2'd2
    } state_t;

    function automatic logic addr_valid(input logic [1:0] addr);
        return addr != c_ADDR_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// ============================================================================
// router_fifo : per-port byte FIFO with registered output and unread-timeout flush
// Rev 1.0
// ============================================================================
module router_fifo #(
    parameter int DATA_W          = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int SOFT_RST_CYCLES = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_vld,
    output logic              o_full
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(SOFT_RST_CYCLES + 1);
    localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_TMO  = c_CW'(SOFT_RST_CYCLES - 1);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic [c_CW-1:0]   r_idle_cnt;

    logic w_wr;
    logic w_rd;
    logic w_idle;
    logic w_flush;

    assign o_vld   = (r_count != '0);
    assign o_full  = (r_count == c_FULL);
    assign w_wr    = i_wr_en && !o_full;
    assign w_rd    = i_rd_en && o_vld;
    assign w_idle  = o_vld && !i_rd_en;
    assign w_flush = w_idle && (r_idle_cnt == c_TMO);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // A flush drops everything already queued but keeps a byte written on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_idle_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_flush) begin
                r_rd_ptr <= r_wr_ptr;
                r_count  <= {{c_AW{1'b0}}, w_wr};
            end else begin
                if (w_rd) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_wr && !w_rd) begin
                    r_count <= r_count + 1'b1;
                end else if (w_rd && !w_wr) begin
                    r_count <= r_count - 1'b1;
                end
            end
            if (w_flush || !w_idle) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_dout <= '0;
        end else if (w_rd) begin
            o_dout <= r_mem[r_rd_ptr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/router_1x3_top.sv
`default_nettype none
// ============================================================================
// router_1x3_top : routes parity-protected byte packets to one of three FIFOs
// Rev 1.0
// ============================================================================
module router_1x3_top #(
    parameter int DATA_W          = router_pkg::DATA_W,
    parameter int FIFO_DEPTH      = router_pkg::FIFO_DEPTH,
    parameter int SOFT_RST_CYCLES = router_pkg::SOFT_RST_CYCLES
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              packet_valid,
    input  logic              read_enb_0,
    input  logic              read_enb_1,
    input  logic              read_enb_2,
    input  logic [DATA_W-1:0] datain,
    output logic              vld_out_0,
    output logic              vld_out_1,
    output logic              vld_out_2,
    output logic              err,
    output logic              busy,
    output logic [DATA_W-1:0] data_out_0,
    output logic [DATA_W-1:0] data_out_1,
    output logic [DATA_W-1:0] data_out_2
);

    import router_pkg::*;

    state_t            r_state;
    state_t            w_next_state;
    logic [1:0]        r_port;
    logic [DATA_W-1:0] r_parity;
    logic [DATA_W-1:0] r_rx_parity;
    logic              r_err;

    logic              w_wr_en;
    logic [1:0]        w_wr_port;
    logic              w_busy;
    logic [3:0]        w_full;
    logic [2:0]        w_vld;
    logic [2:0]        w_rd_req;
    logic [2:0]        w_fifo_wr;
    logic [DATA_W-1:0] w_dout [c_NUM_PORTS];

    assign w_rd_req  = {read_enb_2, read_enb_1, read_enb_0};
    assign w_full[3] = 1'b0;

    // The header selects the port; afterwards the latched port is used.
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_port    = r_port;
        case (r_state)
            DECODE: begin
                w_wr_port = datain[1:0];
                if (packet_valid && addr_valid(datain[1:0])) begin
                    if (w_full[datain[1:0]]) begin
                        w_busy = 1'b1;
                    end else begin
                        w_wr_en      = 1'b1;
                        w_next_state = LOAD_DATA;
                    end
                end
            end
            LOAD_DATA: begin
                if (w_full[r_port]) begin
                    w_busy = 1'b1;
                end else begin
                    w_wr_en = 1'b1;
                    if (!packet_valid) begin
                        w_next_state = CHECK_PARITY;
                    end
                end
            end
            CHECK_PARITY: begin
                w_busy       = 1'b1;
                w_next_state = DECODE;
            end
            default: begin
                w_next_state = DECODE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state     <= DECODE;
            r_port      <= '0;
            r_parity    <= '0;
            r_rx_parity <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                DECODE: begin
                    if (w_wr_en) begin
                        r_port   <= w_wr_port;
                        r_parity <= datain;
                        r_err    <= 1'b0;
                    end
                end
                LOAD_DATA: begin
                    if (w_wr_en) begin
                        if (packet_valid) begin
                            r_parity <= r_parity ^ datain;
                        end else begin
                            r_rx_parity <= datain;
                        end
                    end
                end
                CHECK_PARITY: begin
                    r_err <= (r_parity != r_rx_parity);
                end
                default: begin
                    r_err <= r_err;
                end
            endcase
        end
    end

    for (genvar g = 0; g < c_NUM_PORTS; g++) begin : g_port
        assign w_fifo_wr[g] = w_wr_en && (w_wr_port == 2'(g));

        router_fifo #(
            .DATA_W          (DATA_W),
            .FIFO_DEPTH      (FIFO_DEPTH),
            .SOFT_RST_CYCLES (SOFT_RST_CYCLES)
        ) u_fifo (
            .clk     (clk),
            .rst     (resetn),
            .i_wr_en (w_fifo_wr[g]),
            .i_din   (datain),
            .i_rd_en (w_rd_req[g]),
            .o_dout  (w_dout[g]),
            .o_vld   (w_vld[g]),
            .o_full  (w_full[g])
        );
    end

    assign busy       = w_busy;
    assign err        = r_err;
    assign vld_out_0  = w_vld[0];
    assign vld_out_1  = w_vld[1];
    assign vld_out_2  = w_vld[2];
    assign data_out_0 = w_dout[0];
    assign data_out_1 = w_dout[1];
    assign data_out_2 = w_dout[2];

endmodule
`default_nettype wire

// File: tb/tb_router_1x3_top.sv
`default_nettype none
// ============================================================================
// tb_router_1x3_top : directed/random packet bench with a queue-based reference
// Rev 1.0
// ============================================================================
module tb_router_1x3_top;

    localparam int DEPTH = 16;
    localparam int TMO   = 30;

    logic       clk = 1'b0;
    logic       resetn;
    logic       packet_valid;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [7:0] datain;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       err, busy;
    logic [7:0] data_out_0, data_out_1, data_out_2;

    router_1x3_top dut (
        .clk          (clk),
        .resetn       (resetn),
        .packet_valid (packet_valid),
        .read_enb_0   (read_enb_0),
        .read_enb_1   (read_enb_1),
        .read_enb_2   (read_enb_2),
        .datain       (datain),
        .vld_out_0    (vld_out_0),
        .vld_out_1    (vld_out_1),
        .vld_out_2    (vld_out_2),
        .err          (err),
        .busy         (busy),
        .data_out_0   (data_out_0),
        .data_out_1   (data_out_1),
        .data_out_2   (data_out_2)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: byte queues per port, last-popped byte, idle counters, error flag.
    logic [7:0] q [3][$];
    logic [7:0] exp_dout [3];
    int         idle_cnt [3];
    logic       exp_err;
    logic       chk_pending;
    logic       par_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_vld(input int p);
        case (p)
            0:       return vld_out_0;
            1:       return vld_out_1;
            default: return vld_out_2;
        endcase
    endfunction

    function automatic logic [7:0] get_dout(input int p);
        case (p)
            0:       return data_out_0;
            1:       return data_out_1;
            default: return data_out_2;
        endcase
    endfunction

    task automatic set_rd(input int p, input logic v);
        case (p)
            0:       read_enb_0 = v;
            1:       read_enb_1 = v;
            default: read_enb_2 = v;
        endcase
    endtask

    task automatic model_reset();
        for (int p = 0; p < 3; p++) begin
            q[p].delete();
            exp_dout[p] = 8'h00;
            idle_cnt[p] = 0;
        end
        exp_err     = 1'b0;
        chk_pending = 1'b0;
        par_bad     = 1'b0;
    endtask

    // kind: 0 none, 1 header, 2 payload, 3 parity byte
    task automatic tick(input logic wr, input int wp, input logic [7:0] wd, input int kind);
        logic [2:0] rd;
        logic       had;
        rd = {read_enb_2, read_enb_1, read_enb_0};
        if (chk_pending) begin
            exp_err     = par_bad;
            chk_pending = 1'b0;
        end
        if (kind == 1) exp_err = 1'b0;
        for (int p = 0; p < 3; p++) begin
            had = (q[p].size() != 0);
            if (rd[p] && had) exp_dout[p] = q[p].pop_front();
            if (had && !rd[p]) begin
                idle_cnt[p]++;
                if (idle_cnt[p] == TMO) begin
                    q[p].delete();
                    idle_cnt[p] = 0;
                end
            end else begin
                idle_cnt[p] = 0;
            end
            if (wr && wp == p) q[p].push_back(wd);
        end
        if (kind == 3) chk_pending = 1'b1;
        @(posedge clk);
        #1;
        for (int p = 0; p < 3; p++) begin
            check($sformatf("vld_out_%0d", p), get_vld(p), (q[p].size() != 0));
            check($sformatf("data_out_%0d", p), get_dout(p), exp_dout[p]);
        end
        check("err", err, exp_err);
    endtask

    task automatic send_byte(input int port, input logic pv, input logic [7:0] d, input int kind);
        int guard = 0;
        packet_valid = pv;
        datain       = d;
        @(negedge clk);
        while ((chk_pending || q[port].size() == DEPTH) && guard < 100) begin
            check("busy_stall", busy, 1'b1);
            tick(1'b0, port, d, 0);
            @(negedge clk);
            guard++;
        end
        check("busy_accept", busy, 1'b0);
        tick(1'b1, port, d, kind);
    endtask

    task automatic send_packet(input logic [7:0] hdr, input int n, input logic corrupt);
        int         port;
        logic [7:0] par;
        logic [7:0] b;
        port = int'(hdr[1:0]);
        par  = hdr;
        send_byte(port, 1'b1, hdr, 1);
        check("vld_after_header", get_vld(port), 1'b1);
        for (int i = 0; i < n; i++) begin
            b   = 8'($urandom);
            par = par ^ b;
            send_byte(port, 1'b1, b, 2);
        end
        par_bad = corrupt;
        send_byte(port, 1'b0, corrupt ? (par ^ 8'h01) : par, 3);
        packet_valid = 1'b0;
        datain       = 8'h00;
    endtask

    task automatic drain(input int p);
        int guard = 0;
        set_rd(p, 1'b1);
        while (q[p].size() > 0 && guard < 64) begin
            tick(1'b0, 0, 8'h00, 0);
            guard++;
        end
        set_rd(p, 1'b0);
        tick(1'b0, 0, 8'h00, 0);
        check($sformatf("vld_out_%0d_drained", p), get_vld(p), 1'b0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] par;
        int         guard;

        resetn       = 1'b1;
        packet_valid = 1'b0;
        datain       = 8'h00;
        read_enb_0   = 1'b0;
        read_enb_1   = 1'b0;
        read_enb_2   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld0", vld_out_0, 1'b0);
        check("rst_vld1", vld_out_1, 1'b0);
        check("rst_vld2", vld_out_2, 1'b0);
        check("rst_dout0", data_out_0, 8'h00);
        check("rst_dout1", data_out_1, 8'h00);
        check("rst_dout2", data_out_2, 8'h00);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        resetn = 1'b0;
        tick(1'b0, 0, 8'h00, 0);

        // Port 0: good packet, read back in order
        send_packet(8'h20, 8, 1'b0);
        tick(1'b0, 0, 8'h00, 0);
        check("err_good_p0", err, 1'b0);
        drain(0);

        // Port 1: bad parity, 16 bytes stored, other ports idle
        send_packet(8'h39, 14, 1'b1);
        tick(1'b0, 0, 8'h00, 0);
        check("err_bad_p1", err, 1'b1);
        check("p1_holds", vld_out_1, 1'b1);
        check("p0_empty", vld_out_0, 1'b0);
        check("p2_empty", vld_out_2, 1'b0);
        drain(1);
        check("err_held", err, 1'b1);

        // Port 2: fill FIFO to trigger busy, then release with reads
        par = 8'h46;
        send_byte(2, 1'b1, 8'h46, 1);
        for (int i = 0; i < 18; i++) begin
            b   = 8'($urandom);
            par = par ^ b;
            if (i == 15) begin
                packet_valid = 1'b1;
                datain       = b;
                @(negedge clk);
                check("busy_full", busy, 1'b1);
                tick(1'b0, 2, b, 0);
                @(negedge clk);
                check("busy_full_hold", busy, 1'b1);
                tick(1'b0, 2, b, 0);
                set_rd(2, 1'b1);
            end
            send_byte(2, 1'b1, b, 2);
        end
        par_bad = 1'b0;
        send_byte(2, 1'b0, par, 3);
        packet_valid = 1'b0;
        datain       = 8'h00;
        tick(1'b0, 0, 8'h00, 0);
        check("err_good_p2", err, 1'b0);
        drain(2);

        // Address 3 is ignored
        for (int i = 0; i < 5; i++) begin
            packet_valid = 1'b1;
            datain       = {6'($urandom), 2'b11};
            @(negedge clk);
            check("busy_addr3", busy, 1'b0);
            tick(1'b0, 0, 8'h00, 0);
        end
        packet_valid = 1'b0;
        datain       = 8'h00;
        tick(1'b0, 0, 8'h00, 0);

        // Port 0 left unread until the timeout flush
        send_packet(8'h0C, 3, 1'b0);
        tick(1'b0, 0, 8'h00, 0);
        guard = 0;
        while (q[0].size() > 0 && guard < 60) begin
            tick(1'b0, 0, 8'h00, 0);
            guard++;
        end
        check("soft_flush_vld0", vld_out_0, 1'b0);

        // Reset mid-payload, then a fresh packet to port 1
        send_byte(0, 1'b1, 8'h20, 1);
        for (int i = 0; i < 3; i++) send_byte(0, 1'b1, 8'($urandom), 2);
        #2;
        resetn = 1'b1;
        #1;
        model_reset();
        check("mid_rst_vld0", vld_out_0, 1'b0);
        check("mid_rst_vld1", vld_out_1, 1'b0);
        check("mid_rst_vld2", vld_out_2, 1'b0);
        check("mid_rst_dout0", data_out_0, 8'h00);
        check("mid_rst_dout1", data_out_1, 8'h00);
        check("mid_rst_dout2", data_out_2, 8'h00);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge clk);
        resetn       = 1'b0;
        packet_valid = 1'b0;
        datain       = 8'h00;
        tick(1'b0, 0, 8'h00, 0);
        send_packet(8'h21, 8, 1'b0);
        tick(1'b0, 0, 8'h00, 0);
        check("err_after_rst", err, 1'b0);
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
